// File: rtl/fp16_div_seq.sv
// Multi-cycle binary16 divider: restoring division, one quotient bit per clock.
// DAZ inputs, FTZ result, truncation, canonical NaN 0x7C77; valid/ready on both sides.
module fp16_div_seq (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [15:0] o_res
);

  typedef enum logic [1:0] {StIdle = 2'b00, StDiv = 2'b01, StDone = 2'b10} state_e;

  state_e      r_state;
  logic [12:0] r_rem;
  logic [10:0] r_div;
  logic [10:0] r_q;    // the MSB of the 12-bit quotient only exists in w_q_nxt
  logic [3:0]  r_cnt;
  logic        r_s;
  logic [4:0]  r_ea;
  logic [4:0]  r_eb;
  logic [15:0] r_res;

  logic        w_a_zero, w_a_inf, w_a_nan, w_b_zero, w_b_inf, w_b_nan;
  logic        w_sign, w_special;
  logic [15:0] w_spec_res;

  assign w_a_zero = (i_a[14:10] == 5'd0);
  assign w_a_inf  = (i_a[14:10] == 5'h1F) && (i_a[9:0] == 10'd0);
  assign w_a_nan  = (i_a[14:10] == 5'h1F) && (i_a[9:0] != 10'd0);
  assign w_b_zero = (i_b[14:10] == 5'd0);
  assign w_b_inf  = (i_b[14:10] == 5'h1F) && (i_b[9:0] == 10'd0);
  assign w_b_nan  = (i_b[14:10] == 5'h1F) && (i_b[9:0] != 10'd0);
  assign w_sign   = i_a[15] ^ i_b[15];

  always_comb begin
    w_special  = 1'b1;
    w_spec_res = 16'h0000;
    if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
      w_spec_res = 16'h7C77;
    end else if (w_b_zero || w_a_inf) begin
      w_spec_res = {w_sign, 5'h1F, 10'h000};
    end else if (w_a_zero || w_b_inf) begin
      w_spec_res = {w_sign, 15'h0000};
    end else begin
      w_special = 1'b0;
    end
  end

  logic        w_ge;
  logic [12:0] w_diff;
  logic [12:0] w_rem_nxt;
  logic [11:0] w_q_nxt;
  logic [6:0]  w_e;
  logic [9:0]  w_mant;
  logic [15:0] w_norm_res;

  assign w_ge      = (r_rem >= {2'b00, r_div});
  assign w_diff    = w_ge ? (r_rem - {2'b00, r_div}) : r_rem;
  assign w_rem_nxt = w_diff << 1;
  assign w_q_nxt   = {r_q, w_ge};
  assign w_e       = {2'b00, r_ea} - {2'b00, r_eb} + (w_q_nxt[11] ? 7'd15 : 7'd14);
  assign w_mant    = w_q_nxt[11] ? w_q_nxt[10:1] : w_q_nxt[9:0];

  always_comb begin
    if ($signed(w_e) >= 7'sd31) begin
      w_norm_res = {r_s, 5'h1F, 10'h000};
    end else if ($signed(w_e) <= 7'sd0) begin
      w_norm_res = {r_s, 15'h0000};
    end else begin
      w_norm_res = {r_s, w_e[4:0], w_mant};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_rem   <= 13'd0;
      r_div   <= 11'd0;
      r_q     <= 11'd0;
      r_cnt   <= 4'd0;
      r_s     <= 1'b0;
      r_ea    <= 5'd0;
      r_eb    <= 5'd0;
      r_res   <= 16'h0000;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_valid) begin
            r_s  <= w_sign;
            r_ea <= i_a[14:10];
            r_eb <= i_b[14:10];
            if (w_special) begin
              r_res   <= w_spec_res;
              r_state <= StDone;
            end else begin
              r_rem   <= {2'b01, i_a[9:0]};
              r_div   <= {1'b1, i_b[9:0]};
              r_q     <= 11'd0;
              r_cnt   <= 4'd0;
              r_state <= StDiv;
            end
          end
        end
        StDiv: begin
          r_rem <= w_rem_nxt;
          r_q   <= w_q_nxt[10:0];
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd11) begin
            r_res   <= w_norm_res;
            r_state <= StDone;
          end
        end
        StDone: begin
          if (i_ready) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_ready = (r_state == StIdle);
  assign o_valid = (r_state == StDone);
  assign o_res   = r_res;

endmodule

// File: tb/tb_fp16_div_seq.sv
// Scoreboard bench for fp16_div_seq: the driver pushes hand-computed results,
// a monitor pops and compares whenever o_valid rises.
module tb_fp16_div_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] a = 16'h0000;
  logic [15:0] b = 16'h0000;
  logic        dut_ready;
  logic        dut_valid;
  logic [15:0] dut_res;

  fp16_div_seq u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (in_valid),
    .o_ready (dut_ready),
    .i_a     (a),
    .i_b     (b),
    .o_valid (dut_valid),
    .i_ready (out_ready),
    .o_res   (dut_res)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] res;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   issued = 0;
  int   popped = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, req);
    end
  endtask

  // Monitor: one comparison set per o_valid episode.
  bit seen = 1'b0;
  always @(negedge clk) begin
    #1;
    if (!dut_valid) begin
      seen = 1'b0;
    end else if (!seen) begin
      seen = 1'b1;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid got res %h want none", dut_res);
      end else begin
        exp_t e;
        e = sb.pop_front();
        popped++;
        check({e.name, "_res"}, {16'h0, dut_res}, {16'h0, e.res});
        check({e.name, "_lat"}, 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  // Issue one operation; hold > 0 applies result backpressure for that many cycles.
  task automatic run(input string nm, input logic [15:0] ta, input logic [15:0] tb,
                     input logic [15:0] exp_res, input int lat, input int hold);
    int n;
    logic [15:0] held;
    n = 0;
    while (!dut_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!dut_ready) check({nm, "_ready_timeout"}, 32'd0, 32'd1);
    out_ready = (hold == 0);
    a = ta;
    b = tb;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'h7E00;
    b = 16'h0000;
    sb.push_back('{res: exp_res, lat: lat, acc: cyc, name: nm});
    issued++;
    n = 0;
    while (!dut_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!dut_valid) begin
      check({nm, "_valid_timeout"}, 32'd0, 32'd1);
      return;
    end
    if (hold > 0) begin
      #2;
      held = dut_res;
      for (int i = 0; i < hold; i++) begin
        in_valid = i[0];
        a = 16'h3C00;
        b = 16'h0000;
        @(negedge clk);
        check({nm, "_bp_valid"}, {31'd0, dut_valid}, 32'd1);
        check({nm, "_bp_res"}, {16'h0, dut_res}, {16'h0, held});
        check({nm, "_bp_ready"}, {31'd0, dut_ready}, 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check({nm, "_release_valid"}, {31'd0, dut_valid}, 32'd0);
      check({nm, "_release_ready"}, {31'd0, dut_ready}, 32'd1);
    end else begin
      n = 0;
      while (dut_valid && n < 5) begin
        @(negedge clk);
        n++;
      end
      check({nm, "_back_idle"}, {31'd0, dut_ready}, 32'd1);
    end
  endtask

  initial begin
    #1;
    check("reset_ready", {31'd0, dut_ready}, 32'd1);
    check("reset_valid", {31'd0, dut_valid}, 32'd0);
    check("reset_res", {16'h0, dut_res}, 32'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run("two_by_one",   16'h4000, 16'h3C00, 16'h4000, 12, 0);
    run("one_by_three", 16'h3C00, 16'h4200, 16'h3555, 12, 0);
    run("m5_by_2",      16'hC500, 16'h4000, 16'hC100, 12, 0);
    run("x_by_zero",    16'h3C00, 16'h0000, 16'h7C00, 0, 0);
    run("zero_by_zero", 16'h8000, 16'h0000, 16'h7C77, 0, 0);
    run("nan_in",       16'h7E00, 16'h3C00, 16'h7C77, 0, 0);
    run("inf_by_inf",   16'hFC00, 16'h7C00, 16'h7C77, 0, 0);
    run("fin_by_ninf",  16'h4000, 16'hFC00, 16'h8000, 0, 0);
    run("denorm_daz",   16'h0001, 16'h3C00, 16'h0000, 0, 0);
    run("overflow",     16'h7BFF, 16'h0400, 16'h7C00, 12, 0);
    run("ftz",          16'h0400, 16'h7BFF, 16'h0000, 12, 0);
    run("backpressure", 16'hC500, 16'h4000, 16'hC100, 12, 5);

    // Asynchronous reset in the middle of the iterations.
    a = 16'h4000;
    b = 16'h3C00;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, dut_valid}, 32'd0);
    check("async_rst_ready", {31'd0, dut_ready}, 32'd1);
    check("async_rst_res", {16'h0, dut_res}, 32'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (14) @(negedge clk);
    check("discarded_valid", {31'd0, dut_valid}, 32'd0);
    run("after_reset", 16'h4400, 16'h4000, 16'h4000, 12, 0);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("all_results_seen", 32'(popped), 32'(issued));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
